// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: measures mark/space widths on the demodulated
// receiver pin, assembles 32-bit frames, checks them and publishes a user ID.
module ir_nec_decoder #(
    parameter int         TICK_DIV   = 500,
    parameter bit         ADDR_CHECK = 1'b0,
    parameter logic [7:0] EXP_ADDR   = 8'h00,
    parameter int         USER_MAX   = 10
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic       ir_rx,
    output logic [7:0] ir_address,
    output logic [7:0] ir_command,
    output logic       frame_valid,
    output logic       repeat_pulse,
    output logic       frame_err,
    output logic [3:0] user_id,
    output logic       user_id_valid
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [8:0] USER_LIM = 9'(USER_MAX);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LEAD_SPACE = 3'd1;
    localparam logic [2:0] BIT_MARK   = 3'd2;
    localparam logic [2:0] BIT_SPACE  = 3'd3;
    localparam logic [2:0] STOP_MARK  = 3'd4;
    localparam logic [2:0] RPT_STOP   = 3'd5;

    logic          sync1_reg, sync2_reg, prev_reg;
    logic [PW-1:0] presc_reg;
    logic [10:0]   width_reg;
    logic [2:0]    state_reg;
    logic [5:0]    bit_cnt_reg;
    logic [31:0]   shift_reg;
    logic          have_frame_reg;
    logic [7:0]    ir_address_reg, ir_command_reg;
    logic          frame_valid_reg, repeat_pulse_reg, frame_err_reg;
    logic [3:0]    user_id_reg;
    logic          user_id_valid_reg;

    // Line idles high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= ir_rx;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    logic rise, fall, edge_det, tick;
    assign rise     = sync2_reg & ~prev_reg;   // mark just ended
    assign fall     = ~sync2_reg & prev_reg;   // space just ended
    assign edge_det = rise | fall;
    assign tick     = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            presc_reg <= '0;
            width_reg <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (edge_det)
                width_reg <= '0;
            else if (tick && width_reg != 11'd2047)
                width_reg <= width_reg + 11'd1;
        end
    end

    logic is_lead, is_hdr, is_rpt, is_bit, is_zero, is_one, timeout;
    assign is_lead = (width_reg >= 11'd800) && (width_reg <= 11'd1000);
    assign is_hdr  = (width_reg >= 11'd400) && (width_reg <= 11'd500);
    assign is_rpt  = (width_reg >= 11'd180) && (width_reg <= 11'd270);
    assign is_bit  = (width_reg >= 11'd40)  && (width_reg <= 11'd70);
    assign is_zero = is_bit;
    assign is_one  = (width_reg >= 11'd140) && (width_reg <= 11'd190);
    // A coincident edge takes priority over the timeout.
    assign timeout = (state_reg != IDLE) && !edge_det && (width_reg > 11'd1200);

    logic [7:0] b0, b1, b2, b3;
    logic       frame_ok;
    assign b0 = shift_reg[7:0];
    assign b1 = shift_reg[15:8];
    assign b2 = shift_reg[23:16];
    assign b3 = shift_reg[31:24];
    assign frame_ok = (b1 == ~b0) && (b3 == ~b2) && (!ADDR_CHECK || b0 == EXP_ADDR);

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_reg         <= IDLE;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            have_frame_reg    <= 1'b0;
            ir_address_reg    <= '0;
            ir_command_reg    <= '0;
            frame_valid_reg   <= 1'b0;
            repeat_pulse_reg  <= 1'b0;
            frame_err_reg     <= 1'b0;
            user_id_reg       <= '0;
            user_id_valid_reg <= 1'b0;
        end else begin
            frame_valid_reg  <= 1'b0;
            repeat_pulse_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            if (timeout) begin
                frame_err_reg <= 1'b1;
                state_reg     <= IDLE;
            end else if (edge_det) begin
                case (state_reg)
                    IDLE: begin
                        if (rise && is_lead)
                            state_reg <= LEAD_SPACE;
                    end
                    LEAD_SPACE: begin
                        if (is_hdr) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= BIT_MARK;
                        end else if (is_rpt) begin
                            state_reg <= RPT_STOP;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                    BIT_MARK: begin
                        if (is_bit) begin
                            state_reg <= BIT_SPACE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                    BIT_SPACE: begin
                        if (is_zero || is_one) begin
                            shift_reg   <= {is_one, shift_reg[31:1]};
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            state_reg   <= (bit_cnt_reg == 6'd31) ? STOP_MARK : BIT_MARK;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                    STOP_MARK: begin
                        state_reg <= IDLE;
                        if (is_bit && frame_ok) begin
                            ir_address_reg  <= b0;
                            ir_command_reg  <= b2;
                            frame_valid_reg <= 1'b1;
                            have_frame_reg  <= 1'b1;
                            if ({1'b0, b2} < USER_LIM) begin
                                user_id_reg       <= b2[3:0];
                                user_id_valid_reg <= 1'b1;
                            end
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                    end
                    RPT_STOP: begin
                        state_reg <= IDLE;
                        if (!is_bit)
                            frame_err_reg <= 1'b1;
                        else if (have_frame_reg)
                            repeat_pulse_reg <= 1'b1;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign ir_address    = ir_address_reg;
    assign ir_command    = ir_command_reg;
    assign frame_valid   = frame_valid_reg;
    assign repeat_pulse  = repeat_pulse_reg;
    assign frame_err     = frame_err_reg;
    assign user_id       = user_id_reg;
    assign user_id_valid = user_id_valid_reg;

endmodule
